// File: rtl/stopwatch_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : stopwatch_ctrl_if
// Description : Button levels in, counter/display controls out, for the
//               stopwatch control FSM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stopwatch_ctrl_if;
    logic       start_e;
    logic       pause_e;
    logic       stopp_e;
    logic       reset_e;
    logic       cnt_en;
    logic       cnt_clr;
    logic       disp_on;
    logic [1:0] state;

    modport master (
        output start_e, pause_e, stopp_e, reset_e,
        input  cnt_en, cnt_clr, disp_on, state
    );

    modport slave (
        input  start_e, pause_e, stopp_e, reset_e,
        output cnt_en, cnt_clr, disp_on, state
    );
endinterface

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module      : stopwatch_ctrl
// Description : Stopwatch control FSM: press detection, run/pause/stop
//               sequencing, tick prescaler and pause blink.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int BLINK_DIV = 12500000
) (
    input  wire               clk,
    input  wire               reset,
    stopwatch_ctrl_if.slave   bus
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] c_TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_PAUSE   = 2'b10,
        S_STOPPED = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_presc;
    logic [CW-1:0]   w_presc_nx;
    logic [CW-1:0]   w_presc_inc;
    logic [BW-1:0]   r_blink;
    logic [BW-1:0]   w_blink_nx;
    logic            r_disp;
    logic            w_disp_nx;
    logic            r_clr;
    logic            w_clr_nx;
    logic [3:0]      r_prev;
    logic [3:0]      w_lvl;
    logic [3:0]      w_press;
    logic            w_ev_clr;
    logic            w_ev_stop;
    logic            w_ev_pause;
    logic            w_ev_start;

    assign w_lvl   = {bus.reset_e, bus.stopp_e, bus.pause_e, bus.start_e};
    assign w_press = w_lvl & ~r_prev;

    // Only the highest-priority press of a cycle survives.
    assign w_ev_clr   = w_press[3];
    assign w_ev_stop  = w_press[2] & ~w_press[3];
    assign w_ev_pause = w_press[1] & ~(|w_press[3:2]);
    assign w_ev_start = w_press[0] & ~(|w_press[3:1]);

    assign w_presc_inc = (r_presc == c_TICK_LAST) ? '0 : r_presc + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_blink <= '0;
            r_disp  <= 1'b1;
            r_clr   <= 1'b0;
            r_prev  <= 4'b1111;
        end else begin
            r_state <= w_state_nx;
            r_presc <= w_presc_nx;
            r_blink <= w_blink_nx;
            r_disp  <= w_disp_nx;
            r_clr   <= w_clr_nx;
            r_prev  <= w_lvl;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_blink_nx = '0;
        w_disp_nx  = 1'b1;
        w_clr_nx   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_presc_nx = '0;
                if (w_ev_start) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                // The cycle that samples a pause still counts as run time.
                w_presc_nx = w_presc_inc;
                if (w_ev_stop) begin
                    w_state_nx = S_STOPPED;
                    w_presc_nx = '0;
                end else if (w_ev_pause) begin
                    w_state_nx = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_ev_start || w_ev_pause) begin
                    w_state_nx = S_RUN;
                end else if (w_ev_stop) begin
                    w_state_nx = S_STOPPED;
                    w_presc_nx = '0;
                end else if (r_blink == c_BLINK_LAST) begin
                    w_disp_nx  = ~r_disp;
                end else begin
                    w_blink_nx = r_blink + BW'(1);
                    w_disp_nx  = r_disp;
                end
            end
            S_STOPPED: begin
                w_presc_nx = '0;
                if (w_ev_start) begin
                    w_state_nx = S_RUN;
                    w_clr_nx   = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_presc_nx = '0;
            end
        endcase

        if (w_ev_clr) begin
            w_state_nx = S_IDLE;
            w_presc_nx = '0;
            w_blink_nx = '0;
            w_disp_nx  = 1'b1;
            w_clr_nx   = 1'b1;
        end
    end

    assign bus.state   = r_state;
    assign bus.cnt_en  = (r_state == S_RUN) && (r_presc == c_TICK_LAST);
    assign bus.cnt_clr = r_clr;
    assign bus.disp_on = r_disp;

endmodule

`default_nettype wire
